// File: rtl/vga_timing_gen.sv
// VGA-style raster timing generator: pixel/line counters advanced by a pixel-rate
// enable, with registered sync, visible-region and line/frame start outputs.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 11
) (
  input  logic          block_clk_i,
  input  logic          rst_i,
  input  logic          pix_en_i,
  output logic          h_sync_o,
  output logic          v_sync_o,
  output logic          active_o,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output logic          line_start_o,
  output logic          frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      CW < $clog2(MAX_TOTAL)) begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameters or CW too narrow");
  end

  // hc/vc name the pixel to be emitted on the next enabled cycle
  logic [CW-1:0] hc, vc;
  logic          h_wrap, v_wrap;
  logic          h_sync_d, v_sync_d, active_d;

  assign h_wrap   = (hc == H_LAST);
  assign v_wrap   = (vc == V_LAST);
  assign h_sync_d = (hc >= HS_BEG && hc < HS_END) ? H_POL : ~H_POL;
  assign v_sync_d = (vc >= VS_BEG && vc < VS_END) ? V_POL : ~V_POL;
  assign active_d = (hc < H_ACT) && (vc < V_ACT);

  always_ff @(posedge block_clk_i) begin
    if (rst_i) begin
      hc            <= '0;
      vc            <= '0;
      h_sync_o      <= ~H_POL;
      v_sync_o      <= ~V_POL;
      active_o      <= 1'b0;
      x_o           <= '0;
      y_o           <= '0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      // start pulses last one clock regardless of the enable pattern
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      if (pix_en_i) begin
        h_sync_o      <= h_sync_d;
        v_sync_o      <= v_sync_d;
        active_o      <= active_d;
        x_o           <= hc;
        y_o           <= vc;
        line_start_o  <= (hc == '0);
        frame_start_o <= (hc == '0) && (vc == '0);
        if (h_wrap) begin
          hc <= '0;
          vc <= v_wrap ? '0 : vc + 1'b1;
        end else begin
          hc <= hc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default-horizontal instance with a short frame, plus a tiny
// active-high-sync instance for exhaustive per-pixel patterns.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // default horizontal timing, shortened frame (V_TOTAL = 6 lines)
  logic        rst_m, en_m, hs_m, vs_m, act_m, ls_m, fs_m;
  logic [10:0] x_m, y_m;
  // tiny geometry: 8 pixels x 5 lines, active-high syncs
  logic        rst_s, en_s, hs_s, vs_s, act_s, ls_s, fs_s;
  logic [10:0] x_s, y_s;

  vga_timing_gen #(
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_m (
    .block_clk_i(clk), .rst_i(rst_m), .pix_en_i(en_m),
    .h_sync_o(hs_m), .v_sync_o(vs_m), .active_o(act_m),
    .x_o(x_m), .y_o(y_m), .line_start_o(ls_m), .frame_start_o(fs_m)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut_s (
    .block_clk_i(clk), .rst_i(rst_s), .pix_en_i(en_s),
    .h_sync_o(hs_s), .v_sync_o(vs_s), .active_o(act_s),
    .x_o(x_s), .y_o(y_s), .line_start_o(ls_s), .frame_start_o(fs_s)
  );

  // tiny-instance line/frame patterns, index = hc or vc
  localparam logic [0:7] S_ACT_H = 8'b11110000;
  localparam logic [0:7] S_HS    = 8'b00000110;
  localparam logic [0:4] S_ACT_V = 5'b11000;
  localparam logic [0:4] S_VS    = 5'b00010;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_m = 1'b1; rst_s = 1'b1; en_m = 1'b1; en_s = 1'b1;
    tick();
    checks++;
    if ({hs_m, vs_m, act_m, ls_m, fs_m, x_m, y_m} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0})
      $display("FAIL reset_m got hs=%b vs=%b act=%b ls=%b fs=%b x=%0d y=%0d want 1 1 0 0 0 0 0",
               hs_m, vs_m, act_m, ls_m, fs_m, x_m, y_m);
    else passes++;
    checks++;
    if ({hs_s, vs_s, act_s, ls_s, fs_s, x_s, y_s} !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0})
      $display("FAIL reset_s got hs=%b vs=%b act=%b ls=%b fs=%b x=%0d y=%0d want 0 0 0 0 0 0 0",
               hs_s, vs_s, act_s, ls_s, fs_s, x_s, y_s);
    else passes++;
    rst_m = 1'b0; rst_s = 1'b0; en_m = 1'b0; en_s = 1'b0;
    tick();
    checks++;
    if ({act_m, ls_m, fs_m, x_m} !== {1'b0, 1'b0, 1'b0, 11'd0})
      $display("FAIL reset_hold got act=%b ls=%b fs=%b x=%0d want 0 0 0 0", act_m, ls_m, fs_m, x_m);
    else passes++;
  endtask

  task automatic reset_m();
    rst_m = 1'b1; en_m = 1'b0; tick(); rst_m = 1'b0;
  endtask

  task automatic reset_s();
    rst_s = 1'b1; en_s = 1'b0; tick(); rst_s = 1'b0;
  endtask

  // two full frames of the tiny instance, pixel by pixel
  task automatic test_small_pattern();
    int bad = 0;
    reset_s();
    en_s = 1'b1;
    for (int p = 0; p < 80; p++) begin
      int hc = p % 8;
      int vc = (p / 8) % 5;
      logic [26:0] got, exp;
      tick();
      got = {hs_s, vs_s, act_s, ls_s, fs_s, x_s, y_s};
      exp = {S_HS[hc], S_VS[vc], S_ACT_H[hc] & S_ACT_V[vc], hc == 0, (p % 40) == 0, 11'(hc), 11'(vc)};
      checks++;
      if (got !== exp) begin
        bad++;
        if (bad < 5) $display("FAIL small_pix%0d got %h want %h", p, got, exp);
      end else passes++;
    end
    en_s = 1'b0;
  endtask

  task automatic test_hsync_line();
    int low = 0, act = 0, first_low = -1;
    int ls_t[$];
    reset_m();
    en_m = 1'b1;
    for (int t = 1; t <= 1600; t++) begin
      tick();
      if (t <= 800 && hs_m === 1'b0) begin
        low++;
        if (first_low < 0) first_low = int'(x_m);
      end
      if (t <= 800 && act_m === 1'b1) act++;
      if (ls_m === 1'b1) ls_t.push_back(t);
    end
    en_m = 1'b0;
    checks++;
    if (low !== 96) $display("FAIL hsync_width got %0d want 96", low); else passes++;
    checks++;
    if (first_low !== 656) $display("FAIL hsync_start got x=%0d want 656", first_low); else passes++;
    checks++;
    if (act !== 640) $display("FAIL line_active got %0d want 640", act); else passes++;
    checks++;
    if (ls_t.size() !== 2) $display("FAIL line_start_count got %0d want 2", ls_t.size());
    else if (ls_t[0] !== 1 || ls_t[1] - ls_t[0] !== 800)
      $display("FAIL line_start_period got first=%0d period=%0d want 1 800", ls_t[0], ls_t[1] - ls_t[0]);
    else passes++;
  endtask

  task automatic test_vsync_frame();
    int low = 0, act = 0, first_y = -1, first_x = -1;
    int fs_t[$];
    reset_m();
    en_m = 1'b1;
    for (int t = 1; t <= 9600; t++) begin
      tick();
      if (t <= 4800 && vs_m === 1'b0) begin
        low++;
        if (first_y < 0) begin first_y = int'(y_m); first_x = int'(x_m); end
      end
      if (t <= 4800 && act_m === 1'b1) act++;
      if (fs_m === 1'b1) fs_t.push_back(t);
    end
    en_m = 1'b0;
    checks++;
    if (low !== 1600) $display("FAIL vsync_width got %0d want 1600", low); else passes++;
    checks++;
    if (first_y !== 3 || first_x !== 0)
      $display("FAIL vsync_start got (%0d,%0d) want (0,3)", first_x, first_y);
    else passes++;
    checks++;
    if (act !== 1280) $display("FAIL frame_active got %0d want 1280", act); else passes++;
    checks++;
    if (fs_t.size() !== 2) $display("FAIL frame_start_count got %0d want 2", fs_t.size());
    else if (fs_t[0] !== 1 || fs_t[1] - fs_t[0] !== 4800)
      $display("FAIL frame_start_period got first=%0d period=%0d want 1 4800", fs_t[0], fs_t[1] - fs_t[0]);
    else passes++;
  endtask

  // enable pattern 1,0,0,1: state moves only on enabled clocks
  task automatic test_enable_pattern();
    localparam logic [0:3] EN_PAT = 4'b1001;
    int e = 0, bad = 0;
    int fs_t[$];
    reset_s();
    for (int t = 1; t <= 160; t++) begin
      int p, hc, vc;
      logic [26:0] got, exp;
      logic en;
      en = EN_PAT[(t - 1) % 4];
      en_s = en;
      tick();
      if (en) e++;
      p = e - 1; hc = p % 8; vc = (p / 8) % 5;
      got = {hs_s, vs_s, act_s, ls_s, fs_s, x_s, y_s};
      exp = {S_HS[hc], S_VS[vc], S_ACT_H[hc] & S_ACT_V[vc], en && hc == 0,
             en && (p % 40) == 0, 11'(hc), 11'(vc)};
      checks++;
      if (got !== exp) begin
        bad++;
        if (bad < 5) $display("FAIL enable_clk%0d got %h want %h", t, got, exp);
      end else passes++;
      if (fs_s === 1'b1) fs_t.push_back(t);
    end
    en_s = 1'b0;
    checks++;
    if (fs_t.size() < 2) $display("FAIL enable_frame_count got %0d want >=2", fs_t.size());
    else if (fs_t[0] !== 1 || fs_t[1] !== 81)
      $display("FAIL enable_frame_period got %0d,%0d want 1,81", fs_t[0], fs_t[1]);
    else passes++;
  endtask

  task automatic test_mid_reset();
    reset_m();
    en_m = 1'b1;
    repeat (3100) tick();   // counter now at (700,3); outputs show (699,3)
    checks++;
    if (x_m !== 11'd699 || y_m !== 11'd3)
      $display("FAIL midreset_pos got (%0d,%0d) want (699,3)", x_m, y_m);
    else passes++;
    rst_m = 1'b1;
    tick();
    checks++;
    if ({hs_m, vs_m, act_m, ls_m, fs_m, x_m, y_m} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0})
      $display("FAIL midreset_vals got hs=%b vs=%b act=%b ls=%b fs=%b x=%0d y=%0d want 1 1 0 0 0 0 0",
               hs_m, vs_m, act_m, ls_m, fs_m, x_m, y_m);
    else passes++;
    rst_m = 1'b0;
    tick();
    checks++;
    if ({act_m, ls_m, fs_m, x_m, y_m} !== {1'b1, 1'b1, 1'b1, 11'd0, 11'd0})
      $display("FAIL midreset_restart got act=%b ls=%b fs=%b x=%0d y=%0d want 1 1 1 0 0",
               act_m, ls_m, fs_m, x_m, y_m);
    else passes++;
    en_m = 1'b0;
  endtask

  task automatic test_boundary();
    reset_m();
    en_m = 1'b1;
    repeat (4800) tick();
    checks++;
    if ({x_m, y_m, act_m, vs_m, hs_m, fs_m} !== {11'd799, 11'd5, 1'b0, 1'b1, 1'b1, 1'b0})
      $display("FAIL boundary_last got x=%0d y=%0d act=%b vs=%b hs=%b fs=%b want 799 5 0 1 1 0",
               x_m, y_m, act_m, vs_m, hs_m, fs_m);
    else passes++;
    en_m = 1'b0;
    tick();
    checks++;
    if (x_m !== 11'd799 || fs_m !== 1'b0)
      $display("FAIL boundary_hold got x=%0d fs=%b want 799 0", x_m, fs_m);
    else passes++;
    en_m = 1'b1;
    tick();
    checks++;
    if ({x_m, y_m, ls_m, fs_m, act_m} !== {11'd0, 11'd0, 1'b1, 1'b1, 1'b1})
      $display("FAIL boundary_wrap got x=%0d y=%0d ls=%b fs=%b act=%b want 0 0 1 1 1",
               x_m, y_m, ls_m, fs_m, act_m);
    else passes++;
    en_m = 1'b0;
    tick();
    checks++;
    if ({x_m, ls_m, fs_m} !== {11'd0, 1'b0, 1'b0})
      $display("FAIL boundary_pulse got x=%0d ls=%b fs=%b want 0 0 0", x_m, ls_m, fs_m);
    else passes++;
    en_m = 1'b1;
    tick();
    checks++;
    if ({x_m, y_m, fs_m} !== {11'd1, 11'd0, 1'b0})
      $display("FAIL boundary_next got x=%0d y=%0d fs=%b want 1 0 0", x_m, y_m, fs_m);
    else passes++;
    en_m = 1'b0;
  endtask

  initial begin
    rst_m = 1'b1; rst_s = 1'b1; en_m = 1'b0; en_s = 1'b0;
    test_reset();
    test_small_pattern();
    test_hsync_line();
    test_vsync_frame();
    test_enable_pattern();
    test_mid_reset();
    test_boundary();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, pixels
- H_SYNC, 96, horizontal sync width, pixels
- H_BP, 48, horizontal back porch, pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vertical sync width, lines
- V_BP, 33, vertical back porch, lines
- H_POL, 0, h_sync_o asserted level (0 = active-low)
- V_POL, 0, v_sync_o asserted level (0 = active-low)
- CW, 11, width of the x_o/y_o counters

REQ-002 SHALL have ports (name, direction, width, meaning), one per line, clock and reset first:
- block_clk_i, in, 1, sole clock
- rst_i, in, 1, synchronous active-high reset
- pix_en_i, in, 1, pixel-rate clock enable
- h_sync_o, out, 1, horizontal sync
- v_sync_o, out, 1, vertical sync
- active_o, out, 1, visible-region flag
- x_o, out, CW, horizontal position
- y_o, out, CW, vertical position
- line_start_o, out, 1, first pixel of each line
- frame_start_o, out, 1, first pixel of each frame

REQ-003 SHALL use one clock, block_clk_i; reset is synchronous and active-high.

Function
REQ-004 SHALL define H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP and V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP.
REQ-005 SHALL keep an internal horizontal count hc in 0..H_TOTAL-1 and a vertical count vc in 0..V_TOTAL-1.
REQ-006 SHALL advance hc by 1 only on cycles with pix_en_i = 1; with pix_en_i = 0, all state and outputs hold.
REQ-007 SHALL wrap hc from H_TOTAL-1 to 0 and, on the same cycle, advance vc by 1.
REQ-008 SHALL wrap vc from V_TOTAL-1 to 0 when hc wraps with vc = V_TOTAL-1.
REQ-009 SHALL order regions within each line as: active 0..H_ACTIVE-1, front porch, sync, back porch.
REQ-010 SHALL order regions within each frame the same way: active, front porch, sync, back porch.
REQ-011 SHALL assert h_sync_o (level H_POL) when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, and drive ~H_POL otherwise.
REQ-012 SHALL assert v_sync_o (level V_POL) when V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, and drive ~V_POL otherwise.
REQ-013 SHALL drive active_o = 1 when hc < H_ACTIVE and vc < V_ACTIVE.
REQ-014 SHALL drive x_o = hc and y_o = vc, zero-extended or truncated to CW bits.
REQ-015 SHALL drive line_start_o = 1 exactly when hc = 0, and frame_start_o = 1 exactly when hc = 0 and vc = 0.
REQ-016 SHALL register all outputs, mutually aligned: the outputs for counter state (hc, vc) appear on the cycle after the pix_en_i cycle that loaded that state.
REQ-017 SHALL make line_start_o and frame_start_o one-cycle pulses; they deassert on the next clock even while pix_en_i is low.
REQ-018 SHALL operate correctly with pix_en_i held high (one pixel per clock) and with any irregular enable pattern.
REQ-019 SHALL require, as a parameter-legality rule, every timing parameter >= 1 and CW >= clog2(max(H_TOTAL, V_TOTAL)).

Reset
REQ-020 SHALL, on rst_i = 1 at a clock edge, set hc = 0 and vc = 0.
REQ-021 SHALL, on the same reset edge, drive h_sync_o = ~H_POL, v_sync_o = ~V_POL, active_o = 0, x_o = 0, y_o = 0, line_start_o = 0 and frame_start_o = 0.
REQ-022 SHALL give rst_i priority over pix_en_i.
REQ-023 SHALL, on the first pix_en_i cycle after reset is released, present (hc, vc) = (0, 0) with line_start_o = frame_start_o = 1 and active_o = 1 on the following cycle.
REQ-024 SHALL honour a reset asserted mid-frame on the next edge, with no completion of the current line.

Verification
REQ-025 SHALL cover: defaults, pix_en_i = 1 -> h_sync_o low for exactly 96 clocks per line; line_start_o period exactly 800 clocks.
REQ-026 SHALL cover: defaults -> v_sync_o low for exactly 2 lines (1600 enabled pixels); frame_start_o period exactly 420000 enabled pixels.
REQ-027 SHALL cover: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_* = 2/1/1/1, H_POL=V_POL=1 -> active_o pattern per line 11110000, h_sync_o high at hc 5..6, frame of 40 pixels.
REQ-028 SHALL cover: pix_en_i toggling 1,0,0,1 -> outputs change only after enabled cycles; the frame period scales with the enable count, not clocks.
REQ-029 SHALL cover: rst_i pulsed at hc=700, vc=300 -> next cycle all outputs at reset values; the frame restarts at (0,0).
REQ-030 SHALL cover: boundary at hc=799, vc=524 -> next enabled state is (0,0) with frame_start_o = 1 for one cycle.
